jtdd_mcu_ctrl: RTL and testbench
================================

// Module: jtdd_mcu_ctrl
// PURPOSE
//  Main-CPU-side control stage for the Double Dragon MCU subsystem, directly upstream of the MCU block.
//  Decodes the main CPU's MCU control/status registers and drives the MCU's reset, halt and NMI lines.
//  Arbitrates main CPU access to the shared RAM: stalls the CPU until the MCU is halted.
//  Turns the MCU's IRQ-to-main output into a latched, acknowledgeable FIRQ.
// PARAMETERS
//  NMI_W     4     width in clk cycles of the mcu_nmi_set pulse (>=1)
//  REL_HOLD  8     clk cycles the halt is held after the last shared access before release (>=1)
//  TOUT      1023  clk cycles to wait for mcu_halted before giving up (fits 10 bits)
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  asynchronous reset, active low
//  cpu_cen      in   1  main CPU clock enable; qualifies register writes
//  io_cs        in   1  main CPU select of the MCU control registers
//  cpu_addr     in   2  register index
//  cpu_wrn      in   1  main CPU write strobe, active low
//  cpu_dout     in   8  main CPU write data
//  status_dout  out  8  status register read data
//  com_cs       in   1  main CPU select of the shared RAM window
//  cpu_wait     out  1  stall request to the main CPU, active high
//  mcu_rstb     out  1  MCU reset, active low
//  mcu_halt     out  1  MCU halt request
//  mcu_halted   in   1  MCU halt acknowledge
//  mcu_nmi_set  out  1  NMI trigger pulse to the MCU
//  mcu_irqmain  in   1  MCU interrupt request to the main CPU, level
//  main_firq    out  1  latched FIRQ to the main CPU
// BEHAVIOUR
//  Reset (async): ctrl=8'h02 (MCU held in reset), mcu_halt=0, mcu_nmi_set=0, main_firq=0, timeout=0, FSM=RUN,
//   counters=0, irq edge register=0. Outputs are registered except cpu_wait and status_dout.
//  Register write: occurs on a clk edge with io_cs & ~cpu_wrn & cpu_cen.
//   addr 0  CTRL: bit0 halt_req, bit1 mcu_reset (mcu_rstb=~bit1); other bits stored, no effect.
//   addr 1  NMI: any data loads the NMI counter with NMI_W; mcu_nmi_set=(cnt!=0). A rewrite while counting reloads.
//   addr 2  ACK: clears main_firq and the sticky timeout flag.
//   addr 3  no effect.
//  Read: status_dout = {5'b0, timeout, main_firq, mcu_halted} for any address, combinational.
//  FIRQ: rising edge of mcu_irqmain (registered once) sets main_firq.
//   Set and ACK on the same cycle: set wins.
//  Halt FSM (req = halt_req | com_cs):
//   RUN    mcu_halt=0. If req, go to REQ and clear the timeout counter.
//   REQ    mcu_halt=1 and the timeout counter increments.
//          mcu_halted -> GRANT.
//          Counter reaches TOUT -> set timeout; go to GRANT if req, else RUN.
//   GRANT  mcu_halt=1. If !req, load the hold counter with REL_HOLD and go to REL.
//   REL    mcu_halt=1 and the hold counter decrements. If req -> GRANT.
//          Counter reaches 0 -> RUN; mcu_halt drops on that same edge.
//  cpu_wait = com_cs & ~(FSM in GRANT|REL) & ~mcu_reset. It is combinational, so there is no extra stall
//   once granted. An access that times out proceeds unstalled; the timeout flag marks it.
//  MCU reset: while mcu_reset=1, the FSM is forced to RUN, mcu_halt=0 and com_cs is never stalled.
//   Asserting mcu_reset mid-REQ/GRANT aborts immediately to RUN.
//  Latency: com_cs rising to mcu_halt=1 is 1 clk. mcu_halted rising to cpu_wait=0 is 1 clk.
//  Halt stays asserted while halt_req=1 regardless of com_cs.
// TESTING
//  1 After reset: mcu_rstb=0, status=8'h00. Write CTRL=8'h00 -> mcu_rstb=1 on the next clk.
//  2 com_cs with mcu_halted acked 5 clk after mcu_halt -> cpu_wait high 6 clk, then 0.
//    After com_cs drops, mcu_halt falls exactly REL_HOLD+1 clk later.
//  3 Second com_cs 3 clk into REL -> no stall, mcu_halt stays 1, and the hold counter restarts after it ends.
//  4 mcu_halted never asserted -> cpu_wait releases after TOUT+1 clk and status bit2=1.
//    Write ACK -> bit2=0.
//  5 Write addr1 -> mcu_nmi_set high exactly NMI_W clk. mcu_irqmain rise -> main_firq=1 next clk;
//    ACK coincident with a new rise leaves it 1.
//  6 Write CTRL=8'h02 while in GRANT -> FSM RUN, mcu_halt=0, cpu_wait=0 the next clk.

Source files
------------

// File: rtl/jtdd_mcu_ctrl_if.sv
// Main CPU / MCU signal bundle for the Double Dragon MCU control stage.
// master = CPU and MCU side (testbench), slave = jtdd_mcu_ctrl.
interface jtdd_mcu_ctrl_if;
    logic       cpu_cen;
    logic       io_cs;
    logic [1:0] cpu_addr;
    logic       cpu_wrn;
    logic [7:0] cpu_dout;
    logic [7:0] status_dout;
    logic       com_cs;
    logic       cpu_wait;
    logic       mcu_rstb;
    logic       mcu_halt;
    logic       mcu_halted;
    logic       mcu_nmi_set;
    logic       mcu_irqmain;
    logic       main_firq;

    modport master (
        output cpu_cen, io_cs, cpu_addr, cpu_wrn, cpu_dout, com_cs, mcu_halted, mcu_irqmain,
        input  status_dout, cpu_wait, mcu_rstb, mcu_halt, mcu_nmi_set, main_firq
    );

    modport slave (
        input  cpu_cen, io_cs, cpu_addr, cpu_wrn, cpu_dout, com_cs, mcu_halted, mcu_irqmain,
        output status_dout, cpu_wait, mcu_rstb, mcu_halt, mcu_nmi_set, main_firq
    );
endinterface

// File: rtl/jtdd_mcu_ctrl.sv
// Main-CPU-side MCU control: control/status registers, shared RAM halt arbitration
// and latched FIRQ from the MCU.
module jtdd_mcu_ctrl #(
    parameter int unsigned NMI_W    = 4,
    parameter int unsigned REL_HOLD = 8,
    parameter int unsigned TOUT     = 1023
) (
    input logic            clk,
    input logic            rst_n,
    jtdd_mcu_ctrl_if.slave bus
);
    localparam int unsigned NmiCw  = $clog2(NMI_W + 1);
    localparam int unsigned HoldCw = $clog2(REL_HOLD + 1);
    localparam logic [NmiCw-1:0]  NmiLoad  = NmiCw'(NMI_W);
    localparam logic [HoldCw-1:0] HoldLoad = HoldCw'(REL_HOLD);
    localparam logic [9:0]        ToutLast = 10'(TOUT - 1);

    typedef enum logic [1:0] {StRun, StReq, StGrant, StRel} state_e;

    state_e            state_q, state_d;
    // Only halt_req and mcu_reset have any observable effect, so only they are kept.
    logic [1:0]        ctrl_q, ctrl_d;
    logic [9:0]        tout_cnt_q, tout_cnt_d;
    logic [HoldCw-1:0] hold_q, hold_d;
    logic [NmiCw-1:0]  nmi_cnt_q, nmi_cnt_d;
    logic              timeout_q, timeout_d;
    logic              firq_q, firq_d;
    logic              irq_q;
    logic              halt_q;
    logic              nmi_q;
    logic              wr, wr_ctrl, wr_nmi, wr_ack;
    logic              req, tout_hit;

    assign wr      = bus.io_cs & ~bus.cpu_wrn & bus.cpu_cen;
    assign wr_ctrl = wr & (bus.cpu_addr == 2'd0);
    assign wr_nmi  = wr & (bus.cpu_addr == 2'd1);
    assign wr_ack  = wr & (bus.cpu_addr == 2'd2);
    assign ctrl_d  = wr_ctrl ? bus.cpu_dout[1:0] : ctrl_q;
    assign req     = ctrl_q[0] | bus.com_cs;

    always_comb begin
        state_d    = state_q;
        tout_cnt_d = tout_cnt_q;
        hold_d     = hold_q;
        tout_hit   = 1'b0;
        unique case (state_q)
            StRun: begin
                if (req) begin
                    state_d    = StReq;
                    tout_cnt_d = '0;
                end
            end
            StReq: begin
                tout_cnt_d = tout_cnt_q + 10'd1;
                tout_hit   = (tout_cnt_q == ToutLast);
                if (bus.mcu_halted) state_d = StGrant;
                else if (tout_hit)  state_d = req ? StGrant : StRun;
            end
            StGrant: begin
                if (!req) begin
                    state_d = StRel;
                    hold_d  = HoldLoad;
                end
            end
            StRel: begin
                if (req) begin
                    state_d = StGrant;
                end else begin
                    hold_d = hold_q - HoldCw'(1);
                    if (hold_q == HoldCw'(1)) state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
        // Asserting mcu_reset aborts any halt on the very edge it is written.
        if (ctrl_d[1]) state_d = StRun;
    end

    assign timeout_d = (timeout_q & ~wr_ack) | tout_hit;
    assign firq_d    = (firq_q & ~wr_ack) | (bus.mcu_irqmain & ~irq_q);
    assign nmi_cnt_d = wr_nmi ? NmiLoad :
                       (nmi_cnt_q != '0) ? nmi_cnt_q - NmiCw'(1) : nmi_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            ctrl_q     <= 2'b10;
            tout_cnt_q <= '0;
            hold_q     <= '0;
            nmi_cnt_q  <= '0;
            timeout_q  <= 1'b0;
            firq_q     <= 1'b0;
            irq_q      <= 1'b0;
            halt_q     <= 1'b0;
            nmi_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            tout_cnt_q <= tout_cnt_d;
            hold_q     <= hold_d;
            nmi_cnt_q  <= nmi_cnt_d;
            timeout_q  <= timeout_d;
            firq_q     <= firq_d;
            irq_q      <= bus.mcu_irqmain;
            halt_q     <= (state_d != StRun);
            nmi_q      <= (nmi_cnt_d != '0);
        end
    end

    assign bus.mcu_rstb    = ~ctrl_q[1];
    assign bus.mcu_halt    = halt_q;
    assign bus.mcu_nmi_set = nmi_q;
    assign bus.main_firq   = firq_q;
    assign bus.status_dout = {5'b0, timeout_q, firq_q, bus.mcu_halted};
    assign bus.cpu_wait    = bus.com_cs & ~((state_q == StGrant) | (state_q == StRel)) & ~ctrl_q[1];
endmodule

// File: tb/tb_jtdd_mcu_ctrl.sv
// Self-checking bench for jtdd_mcu_ctrl: directed steps with randomized timing,
// expectations derived from the register/latency rules.
module tb_jtdd_mcu_ctrl;
    localparam int unsigned NmiW    = 4;
    localparam int unsigned RelHold = 8;
    localparam int unsigned Tout    = 1023;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    jtdd_mcu_ctrl_if bus();

    jtdd_mcu_ctrl #(
        .NMI_W   (NmiW),
        .REL_HOLD(RelHold),
        .TOUT    (Tout)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [7:0] d, input logic cen = 1'b1);
        bus.io_cs    = 1'b1;
        bus.cpu_wrn  = 1'b0;
        bus.cpu_cen  = cen;
        bus.cpu_addr = a;
        bus.cpu_dout = d;
        tick();
        bus.io_cs   = 1'b0;
        bus.cpu_wrn = 1'b1;
        bus.cpu_cen = 1'b1;
    endtask

    // Raise com_cs; the MCU acks d edges after mcu_halt rose. Returns stalled cycles.
    task automatic halt_access(input int d, output int nwait);
        int e;
        e     = -1;
        nwait = 0;
        bus.com_cs = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            #1;
            if (!bus.cpu_wait) break;
            nwait++;
            tick();
            if (bus.mcu_halt) e++;
            if (e == d) bus.mcu_halted = 1'b1;
        end
    endtask

    task automatic measure_fall(output int n);
        n = 0;
        for (int t = 0; t < 200; t++) begin
            tick();
            n++;
            if (!bus.mcu_halt) break;
        end
    endtask

    initial begin
        int nw, nf, d, k, m;
        logic [7:0] r;
        logic m_prev, m_firq, irq, ack;

        bus.cpu_cen = 1'b1; bus.io_cs = 1'b0; bus.cpu_addr = 2'd0; bus.cpu_wrn = 1'b1;
        bus.cpu_dout = 8'h00; bus.com_cs = 1'b0; bus.mcu_halted = 1'b0; bus.mcu_irqmain = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick();

        // Reset state; MCU held in reset, shared RAM never stalled.
        chk("rst_rstb", bus.mcu_rstb, 0);
        chk("rst_status", bus.status_dout, 8'h00);
        chk("rst_halt", bus.mcu_halt, 0);
        chk("rst_nmi", bus.mcu_nmi_set, 0);
        chk("rst_firq", bus.main_firq, 0);
        bus.com_cs = 1'b1;
        #1 chk("rst_no_stall", bus.cpu_wait, 0);
        tick(3);
        chk("rst_no_halt", bus.mcu_halt, 0);
        bus.com_cs = 1'b0;
        wr_reg(2'd0, 8'h00, 1'b0);
        chk("ctrl_no_cen", bus.mcu_rstb, 0);
        wr_reg(2'd0, 8'h00);
        chk("ctrl_rstb", bus.mcu_rstb, 1);
        wr_reg(2'd3, 8'($urandom));
        chk("addr3_status", bus.status_dout, 8'h00);
        chk("addr3_rstb", bus.mcu_rstb, 1);

        // Shared access with MCU ack delay d; release after REL_HOLD+1.
        for (int it = 0; it < 6; it++) begin
            d = (it == 0) ? 4 : int'($urandom_range(1, 12));
            halt_access(d, nw);
            chk("grant_wait_len", nw, d + 2);
            chk("grant_halt", bus.mcu_halt, 1);
            chk("grant_status", bus.status_dout, 8'h01);
            bus.com_cs = 1'b0;
            measure_fall(nf);
            chk("release_len", nf, RelHold + 1);
            bus.mcu_halted = 1'b0;
            tick();
        end

        // Re-access during release hold: no stall, hold restarts afterwards.
        for (int it = 0; it < 4; it++) begin
            k = (it == 0) ? 3 : int'($urandom_range(1, RelHold));
            m = int'($urandom_range(1, 5));
            halt_access(2, nw);
            bus.com_cs = 1'b0;
            tick(k);
            bus.com_cs = 1'b1;
            #1 chk("rel_no_stall", bus.cpu_wait, 0);
            chk("rel_halt", bus.mcu_halt, 1);
            repeat (m) begin
                tick();
                chk("rel_hold_wait", bus.cpu_wait, 0);
                chk("rel_hold_halt", bus.mcu_halt, 1);
            end
            bus.com_cs = 1'b0;
            measure_fall(nf);
            chk("rel_restart_len", nf, RelHold + 1);
            bus.mcu_halted = 1'b0;
            tick();
        end

        // MCU never acks: timeout releases the stall and flags status bit2.
        halt_access(1 << 30, nw);
        chk("tout_wait_len", nw, Tout + 1);
        chk("tout_status", bus.status_dout, 8'h04);
        bus.com_cs = 1'b0;
        measure_fall(nf);
        chk("tout_release_len", nf, RelHold + 1);
        wr_reg(2'd2, 8'($urandom));
        chk("tout_ack", bus.status_dout, 8'h00);

        // NMI pulse width and reload.
        chk("nmi_idle", bus.mcu_nmi_set, 0);
        wr_reg(2'd1, 8'($urandom));
        nf = 0;
        for (int t = 0; t < 50; t++) begin
            if (!bus.mcu_nmi_set) break;
            nf++;
            tick();
        end
        chk("nmi_width", nf, NmiW);
        wr_reg(2'd1, 8'($urandom));
        tick(2);
        chk("nmi_mid", bus.mcu_nmi_set, 1);
        wr_reg(2'd1, 8'($urandom));
        nf = 0;
        for (int t = 0; t < 50; t++) begin
            if (!bus.mcu_nmi_set) break;
            nf++;
            tick();
        end
        chk("nmi_reload_width", nf, NmiW);

        // FIRQ latch, ACK, and set-wins on coincident rise.
        bus.mcu_irqmain = 1'b1;
        #1 chk("firq_before_edge", bus.main_firq, 0);
        tick();
        chk("firq_set", bus.main_firq, 1);
        chk("firq_status", bus.status_dout, 8'h02);
        bus.mcu_irqmain = 1'b0;
        tick();
        wr_reg(2'd2, 8'h00);
        chk("firq_ack", bus.main_firq, 0);
        bus.mcu_irqmain = 1'b1;
        wr_reg(2'd2, 8'h00);
        chk("firq_set_wins", bus.main_firq, 1);
        wr_reg(2'd2, 8'h00);
        chk("firq_level_no_reset", bus.main_firq, 0);

        bus.mcu_irqmain = 1'b0;
        tick();
        wr_reg(2'd2, 8'h00);
        m_prev = 1'b0;
        m_firq = 1'b0;
        for (int it = 0; it < 40; it++) begin
            irq = 1'($urandom_range(0, 1));
            ack = ($urandom_range(0, 3) == 0);
            bus.mcu_irqmain = irq;
            if (ack) begin
                wr_reg(2'd2, 8'h00);
            end else begin
                tick();
            end
            if (irq && !m_prev) m_firq = 1'b1;
            else if (ack)       m_firq = 1'b0;
            m_prev = irq;
            chk("firq_rand", bus.main_firq, m_firq);
        end
        bus.mcu_irqmain = 1'b0;
        tick();
        wr_reg(2'd2, 8'h00);

        // mcu_reset while granted aborts the halt at once.
        halt_access(2, nw);
        chk("abort_pre_halt", bus.mcu_halt, 1);
        wr_reg(2'd0, 8'h02);
        chk("abort_halt", bus.mcu_halt, 0);
        chk("abort_wait", bus.cpu_wait, 0);
        chk("abort_rstb", bus.mcu_rstb, 0);
        tick(3);
        chk("abort_stays_run", bus.mcu_halt, 0);
        bus.com_cs = 1'b0;
        bus.mcu_halted = 1'b0;
        wr_reg(2'd0, 8'h00);
        chk("abort_rstb_back", bus.mcu_rstb, 1);

        // halt_req keeps the halt regardless of com_cs.
        wr_reg(2'd0, 8'h01);
        chk("hreq_latency0", bus.mcu_halt, 0);
        tick();
        chk("hreq_halt", bus.mcu_halt, 1);
        bus.mcu_halted = 1'b1;
        tick(2);
        for (int it = 0; it < 20; it++) begin
            bus.com_cs = 1'($urandom_range(0, 1));
            #1;
            chk("hreq_wait", bus.cpu_wait, 0);
            chk("hreq_hold", bus.mcu_halt, 1);
            tick();
        end
        bus.com_cs = 1'b0;
        wr_reg(2'd0, 8'h00);
        measure_fall(nf);
        chk("hreq_release_len", nf, RelHold + 1);
        bus.mcu_halted = 1'b0;

        // Random CTRL values (halt_req clear): mcu_rstb follows bit1.
        for (int it = 0; it < 10; it++) begin
            r = 8'($urandom) & 8'hfe;
            wr_reg(2'd0, r);
            chk("ctrl_rand_rstb", bus.mcu_rstb, {31'd0, ~r[1]});
            chk("ctrl_rand_halt", bus.mcu_halt, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
